// File: rtl/mem_access_unit.sv
// Memory-stage access unit: forwards non-memory results in one cycle and runs
// a single outstanding data-memory load/store with a 16-cycle ack timeout.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_ctrl_in,
    input  logic [15:0] write_back_ctrl_in,
    input  logic [15:0] alu_result_top_half_in,
    input  logic [15:0] alu_result_bottom_half_in,
    input  logic [15:0] inst_in,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        stall,
    output logic        wb_valid_out,
    output logic [15:0] wb_data_out,
    output logic [15:0] wb_ctrl_out,
    output logic [15:0] inst_out,
    output logic        mem_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      state_r;
    logic [3:0]  wait_cnt_r;
    logic [15:0] wb_ctrl_cap_r;
    logic [15:0] inst_cap_r;
    logic        mem_op_s;
    logic        unused_ctrl_s;

    function automatic logic is_mem_op(input logic [1:0] op);
        return op[0] | op[1];
    endfunction

    assign mem_op_s      = is_mem_op(memory_ctrl_in[1:0]);
    assign unused_ctrl_s = ^memory_ctrl_in[15:2];

    // Upstream must hold while a memory op is being accepted or is in flight.
    assign stall = ((state_r == ST_IDLE) && mem_op_s) || (state_r == ST_ACCESS);

    // Access FSM with registered memory-port and write-back outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= 4'd0;
            wb_ctrl_cap_r <= 16'h0000;
            inst_cap_r    <= 16'h0000;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 16'h0000;
            dmem_wdata    <= 16'h0000;
            wb_valid_out  <= 1'b0;
            wb_data_out   <= 16'h0000;
            wb_ctrl_out   <= 16'h0000;
            inst_out      <= 16'h0000;
            mem_err       <= 1'b0;
        end else begin
            wb_valid_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s) begin
                        // A set write bit wins over a set read bit.
                        state_r       <= ST_ACCESS;
                        wait_cnt_r    <= 4'd0;
                        dmem_req      <= 1'b1;
                        dmem_we       <= memory_ctrl_in[1];
                        dmem_addr     <= alu_result_bottom_half_in;
                        dmem_wdata    <= alu_result_top_half_in;
                        wb_ctrl_cap_r <= write_back_ctrl_in;
                        inst_cap_r    <= inst_in;
                    end else begin
                        wb_valid_out <= 1'b1;
                        wb_data_out  <= alu_result_bottom_half_in;
                        wb_ctrl_out  <= write_back_ctrl_in;
                        inst_out     <= inst_in;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state_r      <= ST_IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid_out <= 1'b1;
                        wb_data_out  <= dmem_we ? dmem_addr : dmem_rdata;
                        wb_ctrl_out  <= wb_ctrl_cap_r;
                        inst_out     <= inst_cap_r;
                    end else if (wait_cnt_r == 4'd15) begin
                        // Sixteenth cycle without ack: give up and poison the result.
                        state_r      <= ST_IDLE;
                        dmem_req     <= 1'b0;
                        mem_err      <= 1'b1;
                        wb_valid_out <= 1'b1;
                        wb_data_out  <= 16'hFFFF;
                        wb_ctrl_out  <= wb_ctrl_cap_r;
                        inst_out     <= inst_cap_r;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
